video_frame_arbiter: RTL and testbench

- Shares one AXI-Stream video output between two pixel stream sources (e.g. two pixel generators).
- Grants the output for whole frames only. A switch happens only after the last EOL (tlast) of a frame, and a new grant starts only on an SOF (tuser) word.
- Sits between the pixel sources and the VDMA stream input, with a registered output stage.

---
 rtl/video_frame_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_video_frame_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : video_frame_arbiter
//  Description : Shares one AXI-Stream video output between two pixel sources.
//                Ownership changes only on frame boundaries: a grant starts on
//                an SOF (tuser) word and ends after the Y_SIZE-th accepted
//                EOL (tlast), or when the owner stalls for TIMEOUT cycles.
//                The output is driven from a single registered stage.
//  Ports       : out_stream_aclk / axi_resetn  clock, async active-low reset
//                s0_* / s1_*                   source streams (data/valid/
//                                              ready/SOF/EOL)
//                out_stream_*                  registered output stream,
//                                              tkeep is constant all ones
//                grant                         one-hot owner, 00 when idle
//                frame_done / err_sof /
//                err_timeout                   one-cycle status pulses
//  Options     : `define VIDEO_FRAME_ARBITER_FLUSH_EN makes the arbiter
//                discard non-SOF words offered while idle, so a misaligned
//                source resynchronises to its next SOF.
//  Revision    : 1.0  initial release
// ============================================================================
module video_frame_arbiter #(
    parameter int DATA_W  = 32,
    parameter int Y_SIZE  = 480,
    parameter int TIMEOUT = 1000
) (
    input  logic                  out_stream_aclk,
    input  logic                  axi_resetn,
    input  logic [DATA_W-1:0]     s0_tdata,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic                  s0_tuser,
    input  logic                  s0_tlast,
    input  logic [DATA_W-1:0]     s1_tdata,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    input  logic                  s1_tuser,
    input  logic                  s1_tlast,
    output logic [DATA_W-1:0]     out_stream_tdata,
    output logic [DATA_W/8-1:0]   out_stream_tkeep,
    output logic                  out_stream_tvalid,
    input  logic                  out_stream_tready,
    output logic                  out_stream_tuser,
    output logic                  out_stream_tlast,
    output logic [1:0]            grant,
    output logic                  frame_done,
    output logic                  err_sof,
    output logic                  err_timeout
);

    localparam int c_LINE_W = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam int c_IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_LINE_W-1:0] c_LAST_LINE = c_LINE_W'(Y_SIZE - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX  = c_IDLE_W'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PASS0 = 2'd1;
    localparam logic [1:0] c_ST_PASS1 = 2'd2;

    logic [1:0]          r_state;
    logic [c_LINE_W-1:0] r_line_cnt;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                r_last_grant;   // 0: source 0 owned last, 1: source 1
    logic                r_mid;          // a non-SOF word was taken in this frame
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_user;
    logic                r_out_last;
    logic                r_out_valid;
    logic                r_frame_done;
    logic                r_err_sof;
    logic                r_err_timeout;

    logic                w_sel0;
    logic                w_sel1;
    logic                w_out_free;
    logic                w_src_valid;
    logic [DATA_W-1:0]   w_src_data;
    logic                w_src_user;
    logic                w_src_last;
    logic                w_accept;
    logic                w_frame_end;
    logic                w_sof_err;
    logic                w_req0;
    logic                w_req1;
    logic                w_flush0;
    logic                w_flush1;

    assign w_sel0 = (r_state == c_ST_PASS0);
    assign w_sel1 = (r_state == c_ST_PASS1);

    // The output register can take a word when empty or being drained now.
    assign w_out_free = !r_out_valid || out_stream_tready;

    always_comb begin
        w_src_valid = 1'b0;
        w_src_data  = '0;
        w_src_user  = 1'b0;
        w_src_last  = 1'b0;
        if (w_sel0) begin
            w_src_valid = s0_tvalid;
            w_src_data  = s0_tdata;
            w_src_user  = s0_tuser;
            w_src_last  = s0_tlast;
        end else if (w_sel1) begin
            w_src_valid = s1_tvalid;
            w_src_data  = s1_tdata;
            w_src_user  = s1_tuser;
            w_src_last  = s1_tlast;
        end
    end

    assign w_accept    = (w_sel0 || w_sel1) && w_src_valid && w_out_free;
    assign w_frame_end = w_accept && w_src_last && (r_line_cnt == c_LAST_LINE);
    // An SOF is only legitimate as the very first word of a frame.
    assign w_sof_err   = w_accept && w_src_user && ((r_line_cnt != '0) || r_mid);

    assign w_req0 = s0_tvalid && s0_tuser;
    assign w_req1 = s1_tvalid && s1_tuser;

`ifdef VIDEO_FRAME_ARBITER_FLUSH_EN
    // Gated by reset so that tready stays low while reset is asserted.
    assign w_flush0 = axi_resetn && (r_state == c_ST_IDLE) && s0_tvalid && !s0_tuser;
    assign w_flush1 = axi_resetn && (r_state == c_ST_IDLE) && s1_tvalid && !s1_tuser;
`else
    assign w_flush0 = 1'b0;
    assign w_flush1 = 1'b0;
`endif

    assign s0_tready = (w_sel0 && w_out_free) || w_flush0;
    assign s1_tready = (w_sel1 && w_out_free) || w_flush1;

    // Control state: grant decision, line counting, stall timeout.
    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state       <= c_ST_IDLE;
            r_line_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_last_grant  <= 1'b1;
            r_mid         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_sof     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_frame_done  <= 1'b0;
            r_err_sof     <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_idle_cnt <= '0;
                    r_line_cnt <= '0;
                    r_mid      <= 1'b0;
                    // Round-robin on a tie: the source that did not own last wins.
                    if (w_req0 && (!w_req1 || r_last_grant)) begin
                        r_state <= c_ST_PASS0;
                    end else if (w_req1) begin
                        r_state <= c_ST_PASS1;
                    end
                end
                c_ST_PASS0, c_ST_PASS1: begin
                    if (w_accept) begin
                        r_idle_cnt <= '0;
                        r_err_sof  <= w_sof_err;
                        if (w_frame_end) begin
                            // Frame completion wins over a simultaneous SOF error.
                            r_frame_done <= 1'b1;
                            r_line_cnt   <= '0;
                            r_mid        <= 1'b0;
                            r_last_grant <= w_sel1;
                            r_state      <= c_ST_IDLE;
                        end else if (w_sof_err) begin
                            // Restart the frame on this word; it may also be an EOL.
                            r_line_cnt <= w_src_last ? c_LINE_W'(1) : '0;
                            r_mid      <= 1'b0;
                        end else begin
                            if (w_src_last) begin
                                r_line_cnt <= r_line_cnt + c_LINE_W'(1);
                            end
                            r_mid <= r_mid || !w_src_user;
                        end
                    end else if (!w_src_valid) begin
                        if (r_idle_cnt == c_IDLE_MAX) begin
                            r_err_timeout <= 1'b1;
                            r_idle_cnt    <= '0;
                            r_line_cnt    <= '0;
                            r_mid         <= 1'b0;
                            r_last_grant  <= w_sel1;
                            r_state       <= c_ST_IDLE;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
                        end
                    end else begin
                        // Source valid but output stalled: not a source stall.
                        r_idle_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Output register; keeps draining independently of the grant state.
    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_out_data  <= '0;
            r_out_user  <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= w_src_data;
            r_out_user  <= w_src_user;
            r_out_last  <= w_src_last;
            r_out_valid <= 1'b1;
        end else if (out_stream_tready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_stream_tdata  = r_out_data;
    assign out_stream_tkeep  = '1;
    assign out_stream_tvalid = r_out_valid;
    assign out_stream_tuser  = r_out_user;
    assign out_stream_tlast  = r_out_last;
    assign grant             = {w_sel1, w_sel0};
    assign frame_done        = r_frame_done;
    assign err_sof           = r_err_sof;
    assign err_timeout       = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_video_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_frame_arbiter
//  Description : Self-checking bench for video_frame_arbiter (Y_SIZE=4,
//                TIMEOUT=20, 8 words per line). Source words are queued as
//                {tuser, tlast, tdata}; the expected output stream is the
//                sequence of frames in the order the arbiter must grant them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_video_frame_arbiter;

    localparam int DATA_W  = 32;
    localparam int Y_SIZE  = 4;
    localparam int TIMEOUT = 20;
    localparam int WPL     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                axi_resetn;
    logic [DATA_W-1:0]   s0_tdata, s1_tdata;
    logic                s0_tvalid, s0_tready, s0_tuser, s0_tlast;
    logic                s1_tvalid, s1_tready, s1_tuser, s1_tlast;
    logic [DATA_W-1:0]   out_stream_tdata;
    logic [DATA_W/8-1:0] out_stream_tkeep;
    logic                out_stream_tvalid, out_stream_tready;
    logic                out_stream_tuser, out_stream_tlast;
    logic [1:0]          grant;
    logic                frame_done, err_sof, err_timeout;

    video_frame_arbiter #(
        .DATA_W (DATA_W),
        .Y_SIZE (Y_SIZE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .out_stream_aclk  (clk),
        .axi_resetn       (axi_resetn),
        .s0_tdata         (s0_tdata),
        .s0_tvalid        (s0_tvalid),
        .s0_tready        (s0_tready),
        .s0_tuser         (s0_tuser),
        .s0_tlast         (s0_tlast),
        .s1_tdata         (s1_tdata),
        .s1_tvalid        (s1_tvalid),
        .s1_tready        (s1_tready),
        .s1_tuser         (s1_tuser),
        .s1_tlast         (s1_tlast),
        .out_stream_tdata (out_stream_tdata),
        .out_stream_tkeep (out_stream_tkeep),
        .out_stream_tvalid(out_stream_tvalid),
        .out_stream_tready(out_stream_tready),
        .out_stream_tuser (out_stream_tuser),
        .out_stream_tlast (out_stream_tlast),
        .grant            (grant),
        .frame_done       (frame_done),
        .err_sof          (err_sof),
        .err_timeout      (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    logic [33:0] s0_q[$];
    logic [33:0] s1_q[$];
    logic [33:0] exp_q[$];

    int   cyc, beats, fd_cnt, sof_cnt, to_cnt, viol, s1rdy_cnt;
    int   last_acc0, to_cyc, fd_beats;
    logic fd_last;
    logic [1:0] to_grant;
    bit   rnd_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input int src, input bit user, input bit last, input bit to_exp);
        logic [33:0] w;
        w = {user, last, 32'($urandom)};
        if (src == 0) s0_q.push_back(w);
        else          s1_q.push_back(w);
        if (to_exp) exp_q.push_back(w);
    endtask

    task automatic push_frame(input int src);
        for (int i = 0; i < Y_SIZE * WPL; i++)
            push_word(src, i == 0, (i % WPL) == WPL - 1, 1'b1);
    endtask

    // One clock cycle: observe pulses, drive inputs, record handshakes.
    task automatic cycle();
        logic [33:0] e;
        @(negedge clk);
        cyc++;
        if (frame_done) begin
            fd_cnt++;
            fd_beats = beats;
            fd_last  = out_stream_tvalid & out_stream_tlast;
        end
        if (err_sof) sof_cnt++;
        if (err_timeout) begin
            to_cnt++;
            to_cyc   = cyc;
            to_grant = grant;
        end
        s0_tvalid = (s0_q.size() > 0);
        {s0_tuser, s0_tlast, s0_tdata} = (s0_q.size() > 0) ? s0_q[0] : 34'd0;
        s1_tvalid = (s1_q.size() > 0);
        {s1_tuser, s1_tlast, s1_tdata} = (s1_q.size() > 0) ? s1_q[0] : 34'd0;
        out_stream_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (grant == 2'b01 && s1_tready) viol++;
        if (s1_tready) s1rdy_cnt++;
        if (s0_tvalid && s0_tready) begin
            void'(s0_q.pop_front());
            last_acc0 = cyc;
        end
        if (s1_tvalid && s1_tready) void'(s1_q.pop_front());
        if (out_stream_tvalid && out_stream_tready) begin
            beats++;
            if (exp_q.size() == 0) begin
                chk("extra_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {out_stream_tuser, out_stream_tlast, out_stream_tdata}, e);
            end
        end
    endtask

    task automatic run_until_done();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !out_stream_tvalid) && n < 2000) begin
            cycle();
            n++;
        end
        if (n >= 2000) chk("cycle_budget", 64'd1, 64'd0);
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        axi_resetn = 1'b0;
        #1;
        chk("rst_tvalid", out_stream_tvalid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_s1_tready", s1_tready, 0);
        s0_q.delete(); s1_q.delete(); exp_q.delete();
        s0_tvalid = 0; s0_tuser = 0; s0_tlast = 0; s0_tdata = '0;
        s1_tvalid = 0; s1_tuser = 0; s1_tlast = 0; s1_tdata = '0;
        out_stream_tready = 1'b1;
        repeat (2) @(negedge clk);
        axi_resetn = 1'b1;
        #1;
        chk("rst_pulses", {frame_done, err_sof, err_timeout}, 0);
        chk("rst_tkeep", out_stream_tkeep, 4'hF);
        beats = 0; fd_cnt = 0; sof_cnt = 0; to_cnt = 0; viol = 0; s1rdy_cnt = 0;
        fd_beats = -1; fd_last = 0; to_cyc = -1; last_acc0 = -1; to_grant = 2'b11;
        rnd_ready = 0;
    endtask

    initial begin
        axi_resetn = 1'b0;
        cyc = 0;

        // Single source, single frame, no backpressure.
        do_reset();
        push_frame(0);
        cycle();
        chk("s1_decision_tready", s0_tready, 0);
        cycle();
        chk("s1_grant", grant, 2'b01);
        run_until_done();
        chk("s1_beats", beats, 32);
        chk("s1_fd_cnt", fd_cnt, 1);
        chk("s1_fd_at_word31", fd_beats, 31);
        chk("s1_fd_tlast", fd_last, 1);
        chk("s1_grant_end", grant, 2'b00);

        // Both sources request together right after reset.
        do_reset();
        push_frame(0);
        push_frame(1);
        cycle();
        cycle();
        chk("s2_grant_first", grant, 2'b01);
        run_until_done();
        chk("s2_beats", beats, 64);
        chk("s2_fd_cnt", fd_cnt, 2);
        chk("s2_s1_ready_during_s0", viol, 0);

        // Random output backpressure.
        do_reset();
        rnd_ready = 1;
        push_frame(0);
        run_until_done();
        chk("s3_beats", beats, 32);
        chk("s3_fd_cnt", fd_cnt, 1);
        chk("s3_fd_at_word31", fd_beats, 31);

        // Unexpected SOF on word 3 of line 1 restarts the frame.
        do_reset();
        for (int i = 0; i < WPL + 3; i++)
            push_word(0, i == 0, (i % WPL) == WPL - 1, 1'b1);
        push_frame(0);
        run_until_done();
        chk("s4_beats", beats, WPL + 3 + 32);
        chk("s4_sof_cnt", sof_cnt, 1);
        chk("s4_fd_cnt", fd_cnt, 1);

        // Owner stalls after 10 words; pending source 1 takes over.
        do_reset();
        for (int i = 0; i < 10; i++)
            push_word(0, i == 0, (i % WPL) == WPL - 1, 1'b1);
        cycle();
        cycle();
        push_frame(1);
        run_until_done();
        chk("s5_to_cnt", to_cnt, 1);
        chk("s5_to_delay", to_cyc - last_acc0, 21);
        chk("s5_to_grant", to_grant, 2'b00);
        chk("s5_fd_cnt", fd_cnt, 1);
        chk("s5_beats", beats, 42);

        // Misaligned source: five non-SOF words before its SOF.
        do_reset();
        for (int i = 0; i < 5; i++) push_word(1, 1'b0, 1'b0, 1'b0);
`ifdef VIDEO_FRAME_ARBITER_FLUSH_EN
        push_frame(1);
        run_until_done();
        chk("s6_beats", beats, 32);
        chk("s6_fd_cnt", fd_cnt, 1);
        chk("s6_src_drained", s1_q.size(), 0);
`else
        for (int i = 0; i < Y_SIZE * WPL; i++)
            push_word(1, i == 0, (i % WPL) == WPL - 1, 1'b0);
        repeat (40) cycle();
        chk("s6_beats", beats, 0);
        chk("s6_s1_tready", s1rdy_cnt, 0);
        chk("s6_src_waiting", s1_q.size(), 37);
`endif

        // Reset in the middle of a frame discards everything.
        do_reset();
        rnd_ready = 1;
        push_frame(0);
        repeat (12) cycle();
        do_reset();
        repeat (5) cycle();
        chk("s7_beats_after_reset", beats, 0);
        chk("s7_grant_after_reset", grant, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
